// File: rtl/reg_writeback_pkg.sv
// Shared types and helpers for the register-file write sequencer.
`ifndef FULLW
`define FULLW 32
`endif
`ifndef WB_DEPTH
`define WB_DEPTH 4
`endif

package reg_writeback_pkg;

    localparam int unsigned DATA_WIDTH = `FULLW;
    localparam int unsigned BYTE_WIDTH = 8;

    // Source driving the write port on the next edge.
    typedef enum logic [1:0] {
        SEL_IDLE  = 2'd0,
        SEL_ALU   = 2'd1,
        SEL_QUEUE = 2'd2
    } wr_sel_e;

    // ldrb zero-extends the low byte; word loads pass through.
    function automatic logic [DATA_WIDTH-1:0] load_extend(
        input logic [DATA_WIDTH-1:0] data,
        input logic                  is_byte
    );
        logic [DATA_WIDTH-1:0] result;
        result = data;
        if (is_byte) begin
            result = '0;
            result[BYTE_WIDTH-1:0] = data[BYTE_WIDTH-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/defines.v
// Global datapath widths shared by the CPU core.
`ifndef FULLW
`define FULLW 32
`endif
`ifndef WB_DEPTH
`define WB_DEPTH 4
`endif

// File: rtl/reg_writeback_queue.sv
// In-order load queue: circular buffer with per-entry live bits, squash
// compare and youngest-match search for forwarding and pending status.
`ifndef FULLW
`define FULLW 32
`endif
`ifndef WB_DEPTH
`define WB_DEPTH 4
`endif

module wb_queue #(
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        push_live,
    input  logic [ADDR_WIDTH-1:0]       push_wa,
    input  logic [DATA_WIDTH-1:0]       push_wd,
    input  logic                        pop,
    input  logic                        squash,
    input  logic [ADDR_WIDTH-1:0]       squash_wa,
    output logic                        head_live,
    output logic [ADDR_WIDTH-1:0]       head_wa,
    output logic [DATA_WIDTH-1:0]       head_wd,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(DEPTH):0]      count,
    input  logic [ADDR_WIDTH-1:0]       fwd_a,
    output logic                        fwd_hit,
    output logic [DATA_WIDTH-1:0]       fwd_data,
    output logic [(1<<ADDR_WIDTH)-1:0]  pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]      live_q;
    logic [ADDR_WIDTH-1:0] wa_mem [DEPTH];
    logic [DATA_WIDTH-1:0] wd_mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;

    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign head_live = live_q[rd_ptr];
    assign head_wa   = wa_mem[rd_ptr];
    assign head_wd   = wd_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            wa_mem[wr_ptr] <= push_wa;
            wd_mem[wr_ptr] <= push_wd;
        end
    end

    // Squash first; the pop/push updates below take precedence on their slots.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            live_q  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (squash && wa_mem[PW'(i)] == squash_wa) begin
                    live_q[PW'(i)] <= 1'b0;
                end
            end
            if (pop) begin
                live_q[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + PW'(1);
            end
            if (push) begin
                live_q[wr_ptr] <= push_live;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Walk oldest to youngest so the last live match wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (live_q[idx] && wa_mem[idx] == fwd_a) begin
                fwd_hit  = 1'b1;
                fwd_data = wd_mem[idx];
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (live_q[PW'(i)]) begin
                pending[wa_mem[PW'(i)]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write sequencer: ALU writes take the port at once, loads
// queue in order and drain in idle cycles; exposes forwarding and pending.
`ifndef FULLW
`define FULLW 32
`endif
`ifndef WB_DEPTH
`define WB_DEPTH 4
`endif

module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = `WB_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        alu_valid,
    input  logic [ADDR_WIDTH-1:0]       alu_wa,
    input  logic [`FULLW-1:0]           alu_wd,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic [ADDR_WIDTH-1:0]       ld_wa,
    input  logic [`FULLW-1:0]           ld_wd,
    input  logic                        ld_byte,
    output logic                        we,
    output logic [ADDR_WIDTH-1:0]       wa,
    output logic [`FULLW-1:0]           wd,
    input  logic [ADDR_WIDTH-1:0]       fwd_a,
    output logic                        fwd_hit,
    output logic [`FULLW-1:0]           fwd_data,
    output logic [(1<<ADDR_WIDTH)-1:0]  pending,
    output logic [$clog2(DEPTH):0]      count
);

    wr_sel_e               sel;
    logic                  q_push;
    logic                  q_push_live;
    logic                  q_pop;
    logic                  q_empty;
    logic                  q_full;
    logic                  q_head_live;
    logic [ADDR_WIDTH-1:0] q_head_wa;
    logic [`FULLW-1:0]     q_head_wd;
    logic                  q_fwd_hit;
    logic [`FULLW-1:0]     q_fwd_data;
    logic                  out_hit;

    assign ld_ready    = rst_n && !q_full;
    assign q_push      = ld_valid && ld_ready;
    // A load arriving alongside an ALU write to the same register is older.
    assign q_push_live = !(alu_valid && alu_wa == ld_wa);
    assign q_pop       = (sel == SEL_QUEUE);

    always_comb begin
        sel = SEL_IDLE;
        if (alu_valid) begin
            sel = SEL_ALU;
        end else if (!q_empty) begin
            sel = SEL_QUEUE;
        end
    end

    wb_queue #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .DATA_WIDTH (`FULLW)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (q_push),
        .push_live  (q_push_live),
        .push_wa    (ld_wa),
        .push_wd    (load_extend(ld_wd, ld_byte)),
        .pop        (q_pop),
        .squash     (alu_valid),
        .squash_wa  (alu_wa),
        .head_live  (q_head_live),
        .head_wa    (q_head_wa),
        .head_wd    (q_head_wd),
        .empty      (q_empty),
        .full       (q_full),
        .count      (count),
        .fwd_a      (fwd_a),
        .fwd_hit    (q_fwd_hit),
        .fwd_data   (q_fwd_data),
        .pending    (pending)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we <= 1'b0;
            wa <= '0;
            wd <= '0;
        end else begin
            case (sel)
                SEL_ALU: begin
                    we <= 1'b1;
                    wa <= alu_wa;
                    wd <= alu_wd;
                end
                SEL_QUEUE: begin
                    we <= q_head_live;
                    wa <= q_head_wa;
                    wd <= q_head_wd;
                end
                default: we <= 1'b0;
            endcase
        end
    end

    assign out_hit  = we && (wa == fwd_a);
    assign fwd_hit  = q_fwd_hit || out_hit;
    assign fwd_data = q_fwd_hit ? q_fwd_data : (out_hit ? wd : '0);

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: expected register-file writes are
// queued as stimulus is driven and matched against the write port.
`ifndef FULLW
`define FULLW 32
`endif
`ifndef WB_DEPTH
`define WB_DEPTH 4
`endif

module tb_reg_writeback;

    localparam int AW    = 4;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              alu_valid;
    logic [AW-1:0]     alu_wa;
    logic [31:0]       alu_wd;
    logic              ld_valid;
    logic              ld_ready;
    logic [AW-1:0]     ld_wa;
    logic [31:0]       ld_wd;
    logic              ld_byte;
    logic              we;
    logic [AW-1:0]     wa;
    logic [31:0]       wd;
    logic [AW-1:0]     fwd_a;
    logic              fwd_hit;
    logic [31:0]       fwd_data;
    logic [15:0]       pending;
    logic [2:0]        count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [AW-1:0] wa;
        logic [31:0]   wd;
    } wr_t;

    typedef struct packed {
        logic          live;
        logic [AW-1:0] wa;
        logic [31:0]   wd;
    } ent_t;

    wr_t  sb[$];
    ent_t mq[$];
    logic          mwe;
    logic [AW-1:0] mwa;
    logic [31:0]   mwd;

    reg_writeback #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_wa    (alu_wa),
        .alu_wd    (alu_wd),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_wa     (ld_wa),
        .ld_wd     (ld_wd),
        .ld_byte   (ld_byte),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .fwd_a     (fwd_a),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .pending   (pending),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Every issued write must be the next expected one.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got wa=%0d wd=%h, expected no write", wa, wd);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (wa !== e.wa || wd !== e.wd) begin
                    errors++;
                    $display("FAIL write_order: got wa=%0d wd=%h, expected wa=%0d wd=%h",
                             wa, wd, e.wa, e.wd);
                end
            end
        end
    end

    function automatic logic [15:0] model_pending();
        logic [15:0] p;
        p = '0;
        foreach (mq[i]) if (mq[i].live) p[mq[i].wa] = 1'b1;
        return p;
    endfunction

    function automatic logic [32:0] model_fwd(input logic [AW-1:0] a);
        logic [32:0] r;
        r = '0;
        if (mwe && mwa == a) r = {1'b1, mwd};
        foreach (mq[i]) if (mq[i].live && mq[i].wa == a) r = {1'b1, mq[i].wd};
        return r;
    endfunction

    // Drive one cycle of stimulus and advance the reference model across the edge.
    task automatic cycle(input logic av, input logic [AW-1:0] aw, input logic [31:0] ad,
                         input logic lv, input logic [AW-1:0] lw, input logic [31:0] ld,
                         input logic lb, output logic acc);
        ent_t e;
        acc       = lv && (mq.size() < DEPTH);
        alu_valid = av; alu_wa = aw; alu_wd = ad;
        ld_valid  = lv; ld_wa = lw; ld_wd = ld; ld_byte = lb;
        if (av) begin
            foreach (mq[i]) if (mq[i].wa == aw) mq[i].live = 1'b0;
            sb.push_back('{wa: aw, wd: ad});
            mwe = 1'b1; mwa = aw; mwd = ad;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            mwe = e.live; mwa = e.wa; mwd = e.wd;
            if (e.live) sb.push_back('{wa: e.wa, wd: e.wd});
        end else begin
            mwe = 1'b0;
        end
        if (acc) mq.push_back('{live: !(av && aw == lw), wa: lw, wd: lb ? {24'b0, ld[7:0]} : ld});
        @(posedge clk); #1;
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, acc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mq.delete(); mwe = 1'b0; mwa = '0; mwd = '0;
        checks++; if (we !== 1'b0)    begin errors++; $display("FAIL reset_we: got %b expected 0", we); end
        checks++; if (wa !== '0)      begin errors++; $display("FAIL reset_wa: got %0d expected 0", wa); end
        checks++; if (wd !== '0)      begin errors++; $display("FAIL reset_wd: got %h expected 0", wd); end
        checks++; if (count !== '0)   begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (pending !== '0) begin errors++; $display("FAIL reset_pending: got %h expected 0", pending); end
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready: got %b expected 0", ld_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL release_ld_ready: got %b expected 1", ld_ready); end
    endtask

    task automatic test_alu_only();
        logic acc;
        cycle(1'b1, 4'd3, 32'h11, 1'b0, '0, '0, 1'b0, acc);
        checks++; if (we !== 1'b1 || wa !== 4'd3 || wd !== 32'h11)
            begin errors++; $display("FAIL alu_write: got we=%b wa=%0d wd=%h expected 1/3/11", we, wa, wd); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL alu_count: got %0d expected 0", count); end
        idle(1);
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL alu_idle_we: got %b expected 0", we); end
    endtask

    task automatic test_load_path();
        logic acc;
        cycle(1'b0, '0, '0, 1'b1, 4'd5, 32'hAABBCCDD, 1'b1, acc);
        checks++; if (pending !== 16'h0020) begin errors++; $display("FAIL load_pending_set: got %h expected 0020", pending); end
        checks++; if (we !== 1'b0 || count !== 3'd1)
            begin errors++; $display("FAIL load_queued: got we=%b count=%0d expected 0/1", we, count); end
        idle(1);
        checks++; if (we !== 1'b1 || wa !== 4'd5 || wd !== 32'hDD)
            begin errors++; $display("FAIL load_write: got we=%b wa=%0d wd=%h expected 1/5/dd", we, wa, wd); end
        checks++; if (pending !== '0 || count !== 3'd0)
            begin errors++; $display("FAIL load_pending_clear: got pending=%h count=%0d expected 0/0", pending, count); end
        idle(1);
    endtask

    task automatic test_fill_starve();
        logic acc;
        int li = 0;
        for (int k = 0; k < 6; k++) begin
            checks++; if (ld_ready !== (mq.size() < DEPTH))
                begin errors++; $display("FAIL starve_ready: got %b expected %b at k=%0d", ld_ready, mq.size() < DEPTH, k); end
            cycle(1'b1, 4'd1, 32'h100 + k, li < 5, AW'(10 + li), 32'hC0 + li, 1'b0, acc);
            if (acc) li++;
        end
        checks++; if (count !== 3'd4 || ld_ready !== 1'b0)
            begin errors++; $display("FAIL starve_full: got count=%0d ready=%b expected 4/0", count, ld_ready); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (ld_ready !== (mq.size() < DEPTH))
                begin errors++; $display("FAIL drain_ready: got %b expected %b at k=%0d", ld_ready, mq.size() < DEPTH, k); end
            cycle(1'b0, '0, '0, li < 5, AW'(10 + li), 32'hC0 + li, 1'b0, acc);
            if (acc) li++;
            checks++; if (we !== 1'b1) begin errors++; $display("FAIL drain_consecutive: got we=%b expected 1 at k=%0d", we, k); end
        end
        idle(1);
        checks++; if (count !== 3'd0 || we !== 1'b0)
            begin errors++; $display("FAIL drain_empty: got count=%0d we=%b expected 0/0", count, we); end
    endtask

    task automatic test_squash();
        logic acc;
        cycle(1'b0, '0, '0, 1'b1, 4'd2, 32'h55, 1'b0, acc);
        checks++; if (pending[2] !== 1'b1) begin errors++; $display("FAIL squash_pending_set: got %b expected 1", pending[2]); end
        cycle(1'b1, 4'd2, 32'h7, 1'b0, '0, '0, 1'b0, acc);
        checks++; if (pending !== '0 || count !== 3'd1)
            begin errors++; $display("FAIL squash_dead: got pending=%h count=%0d expected 0/1", pending, count); end
        idle(1);
        checks++; if (we !== 1'b0 || count !== 3'd0)
            begin errors++; $display("FAIL squash_pop: got we=%b count=%0d expected 0/0", we, count); end
        // Same-cycle load and ALU write to one register: load is older.
        cycle(1'b1, 4'd2, 32'h9, 1'b1, 4'd2, 32'h66, 1'b0, acc);
        checks++; if (pending !== '0 || count !== 3'd1)
            begin errors++; $display("FAIL same_cycle_dead: got pending=%h count=%0d expected 0/1", pending, count); end
        idle(1);
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL same_cycle_pop: got we=%b expected 0", we); end
        idle(1);
    endtask

    task automatic test_forwarding();
        logic acc;
        logic [32:0] m;
        cycle(1'b1, 4'd1, 32'hA, 1'b1, 4'd4, 32'h1, 1'b0, acc);
        cycle(1'b1, 4'd1, 32'hB, 1'b1, 4'd4, 32'h2, 1'b0, acc);
        fwd_a = 4'd4; #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h2)
            begin errors++; $display("FAIL fwd_youngest: got hit=%b data=%h expected 1/2", fwd_hit, fwd_data); end
        fwd_a = 4'd1; #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hB)
            begin errors++; $display("FAIL fwd_outreg: got hit=%b data=%h expected 1/b", fwd_hit, fwd_data); end
        fwd_a = 4'd4;
        for (int k = 0; k < 3; k++) begin
            idle(1);
            m = model_fwd(4'd4);
            checks++; if ({fwd_hit, fwd_data} !== m)
                begin errors++; $display("FAIL fwd_drain: got hit=%b data=%h expected hit=%b data=%h at k=%0d", fwd_hit, fwd_data, m[32], m[31:0], k); end
            checks++; if (pending !== model_pending())
                begin errors++; $display("FAIL fwd_pending: got %h expected %h at k=%0d", pending, model_pending(), k); end
        end
        checks++; if (fwd_hit !== 1'b0 || fwd_data !== '0)
            begin errors++; $display("FAIL fwd_committed: got hit=%b data=%h expected 0/0", fwd_hit, fwd_data); end
    endtask

    task automatic test_reset_mid();
        logic acc;
        for (int k = 0; k < 3; k++) cycle(1'b1, 4'd1, 32'h200 + k, 1'b1, AW'(6 + k), 32'hE0 + k, 1'b0, acc);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_count: got %0d expected 3", count); end
        rst_n = 1'b0;
        ld_valid = 1'b1; ld_wa = 4'd9; ld_wd = 32'hBAD; ld_byte = 1'b0;
        @(posedge clk); #1;
        mq.delete(); mwe = 1'b0; mwa = '0; mwd = '0;
        checks++; if (we !== 1'b0 || count !== '0 || pending !== '0 || ld_ready !== 1'b0)
            begin errors++; $display("FAIL mid_reset: got we=%b count=%0d pending=%h ready=%b expected 0/0/0/0", we, count, pending, ld_ready); end
        ld_valid = 1'b0;
        rst_n = 1'b1;
        idle(6);
        checks++; if (count !== '0 || pending !== '0)
            begin errors++; $display("FAIL mid_after: got count=%0d pending=%h expected 0/0", count, pending); end
    endtask

    initial begin
        rst_n = 1'b0; alu_valid = 1'b0; alu_wa = '0; alu_wd = '0;
        ld_valid = 1'b0; ld_wa = '0; ld_wd = '0; ld_byte = 1'b0; fwd_a = '0;
        mwe = 1'b0; mwa = '0; mwd = '0;
        test_reset();
        test_alu_only();
        test_load_path();
        test_fill_starve();
        test_squash();
        test_forwarding();
        test_reset_mid();
        idle(2);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL missing_writes: got %0d outstanding expected 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-side sequencer for the CPU register file: it collects destination writes from the ALU path and the load path and produces exactly one registered write per cycle on the file's write port (`we`/`wa`/`wd`). ALU results take the port immediately. Load results are buffered in a small in-order queue and drained in the gaps. Queued writes stay architecturally ordered with younger ALU writes, and the block exposes forwarding and pending-load status for the registered read ports.

## Interface
- `ADDR_WIDTH`, 4, register address width; the file holds 2^ADDR_WIDTH registers.
- `DEPTH`, 4, load-queue entries (power of two, ≥2).
- Data width is `` `FULLW `` from defines.v; it is not a parameter.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `alu_valid`  in  1  ALU result present this cycle; always accepted.
- `alu_wa`  in  ADDR_WIDTH  ALU destination.
- `alu_wd`  in  `FULLW`  ALU result.
- `ld_valid`  in  1  load result offered.
- `ld_ready`  out  1  queue can accept a load this cycle.
- `ld_wa`  in  ADDR_WIDTH  load destination.
- `ld_wd`  in  `FULLW`  load data.
- `ld_byte`  in  1  ldrb: write `{24'b0, ld_wd[7:0]}`.
- `we`  out  1  register-file write enable (registered).
- `wa`  out  ADDR_WIDTH  register-file write address (registered).
- `wd`  out  `FULLW`  register-file write data (registered).
- `fwd_a`  in  ADDR_WIDTH  forwarding lookup address.
- `fwd_hit`  out  1  a not-yet-committed write to `fwd_a` exists.
- `fwd_data`  out  `FULLW`  youngest such value.
- `pending`  out  2^ADDR_WIDTH  bit r set while a live queued load targets r.
- `count`  out  $clog2(DEPTH)+1  queue occupancy.

## Operation
- A load is accepted when `ld_valid && ld_ready`.
  - `ld_ready = (count < DEPTH)`, from registered occupancy only.
  - It does not depend on a same-cycle pop.
- Byte extension is applied at enqueue.
- Each entry holds {live, wa, wd}.
- Write-port selection, one per cycle, with priority:
  1. `alu_valid` → next `we=1`, `wa=alu_wa`, `wd=alu_wd`.
  2. Otherwise, if the queue is non-empty, pop the head. Next `we` = head.live, with head wa/wd.
  3. Otherwise, `we=0`. `wa`/`wd` hold their previous values.
- Squash rule:
  - An ALU write to r clears `live` on every queued entry with wa==r, because the ALU write is younger.
  - A load accepted in the same cycle as an ALU write to the same r counts as older. It is enqueued with live=0.
- Dead entries still occupy slots. They pop normally, produce `we=0`, and drain at one per idle cycle.
- Forwarding, combinational from state and `fwd_a`:
  - Check the youngest live queue entry matching `fwd_a` first.
  - Then check the output register when `we && wa==fwd_a`.
  - `fwd_data` is 0 when there is no hit.
- `pending[r]` = OR over live entries with wa==r.
- Pointers wrap modulo DEPTH. Push and pop in the same cycle leave `count` unchanged.
- Full queue with `ld_valid` high: the load is not accepted and the producer holds.

## Timing
- ALU write at edge N → `we`/`wa`/`wd` visible after edge N. One-cycle latency.
- Load accepted at edge N into an empty queue with no ALU traffic → popped at edge N+1, write visible after N+1. Two-cycle latency.
- Continuous `alu_valid` starves the queue. `ld_ready` drops once `count==DEPTH`.
- Reset (`rst_n` low at an edge):
  - `we=0`, `wa=0`, `wd=0`, `count=0`, all entries dead, `pending=0`.
  - `ld_ready=0` while `rst_n` is low; it is 1 on the first cycle after release.
- Reset mid-operation discards all queued and in-flight writes; no write is issued for them.

## Structure
- defines.v already provides `` `FULLW ``. Add `` `WB_DEPTH `` as the default for `DEPTH` there.
- Sub-module `wb_queue` contains:
  - circular buffer, pointers and count;
  - live bits with the parallel squash compare;
  - youngest-match search used by forwarding and `pending`.
- The top level holds the write-port register and the priority mux.

## Test plan
- ALU-only: `alu_valid` with wa=3, wd=0x11 → next cycle `we=1`, `wa=3`, `wd=0x11`; `count` stays 0.
- Load path: ld wa=5, wd=0xAABBCCDD, `ld_byte=1` into an idle block → two cycles later `we=1`, `wa=5`, `wd=0xDD`; `pending[5]` high for exactly one cycle.
- Fill and starve:
  - Hold `alu_valid` and offer 5 loads with DEPTH=4 → 4 accepted, then `ld_ready=0`.
  - Drop `alu_valid` → the 4 loads drain in order on consecutive cycles.
  - The 5th load is accepted on the first cycle `count<4`.
- Squash:
  - Queue a load to r2, then ALU writes r2=0x7 → the load pops with `we=0` and the register file never sees it.
  - Same-cycle load and ALU to r2 → only the ALU write is issued.
- Forwarding: queue loads r4=0x1 then r4=0x2 → `fwd_a=4` gives hit=1, data=0x2; after both commit, hit=0.
- Reset with 3 queued entries → next cycle `we=0`, `count=0`, `pending=0`, `ld_ready=0`; no writes follow the release.
